// File: rtl/tdm_demux16_if.sv
// Bus bundle between a TDM serial source/parallel consumer and tdm_demux16.
// The master is the environment (source + consumer); the slave is the demux.
interface tdm_demux16_if;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;

    logic          din;
    logic          din_valid;
    logic          frame_start;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [SW-1:0] sel;
    logic          busy;
    logic          overrun;

    modport master (
        output din, din_valid, frame_start, dout_ready,
        input  dout, dout_valid, sel, busy, overrun
    );

    modport slave (
        input  din, din_valid, frame_start, dout_ready,
        output dout, dout_valid, sel, busy, overrun
    );
endinterface

// File: rtl/tdm_demux16.sv
// 16-slot TDM serial-to-parallel demultiplexer with a one-word output buffer,
// frame resync and a sticky overrun flag for words dropped under backpressure.
module tdm_demux16 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    tdm_demux16_if.slave bus
);
    localparam int unsigned W  = 16;
    localparam int unsigned SW = 4;

    logic [SW-1:0] sel_q, sel_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          overrun_q, overrun_d;

    logic          complete_c;
    logic [W-1:0]  word_c;
    logic [W-1:0]  mapped_c;

    // Slot 15 being written this cycle finishes the frame; fold that bit in directly.
    assign complete_c = bus.din_valid && !bus.frame_start && (sel_q == SW'(W - 1));
    assign word_c     = {bus.din, shadow_q[W-2:0]};

    generate
        if (LSB_FIRST) begin : g_lsb
            assign mapped_c = word_c;
        end else begin : g_msb
            for (genvar i = 0; i < W; i++) begin : g_rev
                assign mapped_c[i] = word_c[W-1-i];
            end
        end
    endgenerate

    // Slot counter and shadow register update.
    always_comb begin
        sel_d    = sel_q;
        shadow_d = shadow_q;
        if (bus.din_valid) begin
            if (bus.frame_start) begin
                shadow_d[0] = bus.din;
                sel_d       = SW'(1);
            end else begin
                shadow_d[sel_q] = bus.din;
                sel_d           = sel_q + SW'(1);
            end
        end else if (bus.frame_start) begin
            sel_d = '0;
        end
    end

    // Output buffer: load when empty or being drained, otherwise drop and flag.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        if (complete_c) begin
            if (!dout_valid_q || bus.dout_ready) begin
                dout_d       = mapped_c;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && bus.dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.sel        = sel_q;
    assign bus.busy       = (sel_q != '0);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 (LSB-first and MSB-first instances).
module tb_tdm_demux16;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    tdm_demux16_if bus0 ();
    tdm_demux16_if bus1 ();

    tdm_demux16 #(.LSB_FIRST(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    tdm_demux16 #(.LSB_FIRST(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; outputs are observed 1 ns after the rising edge.
    task automatic send_bit(input int inst, input logic d, input logic v, input logic fs);
        @(negedge clk);
        if (inst == 0) begin
            bus0.din = d; bus0.din_valid = v; bus0.frame_start = fs;
        end else begin
            bus1.din = d; bus1.din_valid = v; bus1.frame_start = fs;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int inst, input logic [15:0] w);
        for (int i = 0; i < 16; i++) send_bit(inst, w[i], 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus0.din = 0; bus0.din_valid = 0; bus0.frame_start = 0; bus0.dout_ready = 1;
        bus1.din = 0; bus1.din_valid = 0; bus1.frame_start = 0; bus1.dout_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus0.sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus0.sel); end
        n_cmp++; if (bus0.dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h want 0000", bus0.dout); end
        n_cmp++; if (bus0.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus0.dout_valid); end
        n_cmp++; if (bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus0.overrun); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
    endtask

    task automatic test_walking_one;
        logic [15:0] exp;
        int          vcnt;
        bus0.dout_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            vcnt = 0;
            for (int i = 0; i < 16; i++) begin
                send_bit(0, (i == k), 1'b1, 1'b0);
                if (bus0.dout_valid === 1'b1) vcnt++;
                if (k == 5 && i == 3) begin
                    n_cmp++; if (bus0.sel !== 4'd4) begin n_fail++; $display("FAIL walk_sel got %0d want 4", bus0.sel); end
                    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL walk_busy got %b want 1", bus0.busy); end
                end
            end
            exp = 16'h0001 << k;
            n_cmp++; if (bus0.dout !== exp) begin n_fail++; $display("FAIL walk_dout k=%0d got %h want %h", k, bus0.dout, exp); end
            n_cmp++; if (vcnt != 1) begin n_fail++; $display("FAIL walk_valid_cycles k=%0d got %0d want 1", k, vcnt); end
            n_cmp++; if (bus0.sel !== 4'd0) begin n_fail++; $display("FAIL walk_wrap k=%0d got %0d want 0", k, bus0.sel); end
        end
    endtask

    task automatic test_gapped;
        logic [15:0] w;
        logic [3:0]  exp_sel;
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            send_bit(0, w[i], 1'b1, 1'b0);
            exp_sel = 4'(i + 1);
            n_cmp++; if (bus0.sel !== exp_sel) begin n_fail++; $display("FAIL gap_sel_adv i=%0d got %0d want %0d", i, bus0.sel, exp_sel); end
            if (i < 15) begin
                send_bit(0, ~w[i], 1'b0, 1'b0);
                n_cmp++; if (bus0.sel !== exp_sel) begin n_fail++; $display("FAIL gap_sel_hold i=%0d got %0d want %0d", i, bus0.sel, exp_sel); end
            end
        end
        n_cmp++; if (bus0.dout !== 16'hA5C3) begin n_fail++; $display("FAIL gap_dout got %h want a5c3", bus0.dout); end
        n_cmp++; if (bus0.dout_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b want 1", bus0.dout_valid); end
    endtask

    task automatic test_backpressure;
        send_bit(0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus0.dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", bus0.dout_valid); end
        bus0.dout_ready = 1'b0;
        send_word(0, 16'h1234);
        n_cmp++; if (bus0.dout !== 16'h1234) begin n_fail++; $display("FAIL bp_first got %h want 1234", bus0.dout); end
        n_cmp++; if (bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL bp_no_overrun got %b want 0", bus0.overrun); end
        send_word(0, 16'hFFFF);
        n_cmp++; if (bus0.dout !== 16'h1234) begin n_fail++; $display("FAIL bp_retain got %h want 1234", bus0.dout); end
        n_cmp++; if (bus0.dout_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", bus0.dout_valid); end
        n_cmp++; if (bus0.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", bus0.overrun); end
        bus0.dout_ready = 1'b1;
        send_bit(0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus0.dout_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume got %b want 0", bus0.dout_valid); end
        n_cmp++; if (bus0.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", bus0.overrun); end
        n_cmp++; if (bus0.dout !== 16'h1234) begin n_fail++; $display("FAIL bp_hold got %h want 1234", bus0.dout); end
    endtask

    task automatic test_resync;
        for (int i = 0; i < 7; i++) send_bit(0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus0.sel !== 4'd7) begin n_fail++; $display("FAIL rs_partial got %0d want 7", bus0.sel); end
        send_bit(0, 1'b1, 1'b0, 1'b1);
        n_cmp++; if (bus0.sel !== 4'd0) begin n_fail++; $display("FAIL rs_sel got %0d want 0", bus0.sel); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy got %b want 0", bus0.busy); end
        n_cmp++; if (bus0.dout !== 16'h1234 || bus0.dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL rs_no_output got %h/%b want 1234/0", bus0.dout, bus0.dout_valid); end
        send_word(0, 16'h00FF);
        n_cmp++; if (bus0.dout !== 16'h00FF) begin n_fail++; $display("FAIL rs_dout got %h want 00ff", bus0.dout); end
        n_cmp++; if (bus0.dout_valid !== 1'b1) begin n_fail++; $display("FAIL rs_valid got %b want 1", bus0.dout_valid); end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 9; i++) send_bit(0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.sel !== 4'd0) begin n_fail++; $display("FAIL rm_sel got %0d want 0", bus0.sel); end
        n_cmp++; if (bus0.dout !== 16'h0000) begin n_fail++; $display("FAIL rm_dout got %h want 0000", bus0.dout); end
        n_cmp++; if (bus0.overrun !== 1'b0) begin n_fail++; $display("FAIL rm_overrun got %b want 0", bus0.overrun); end
        n_cmp++; if (bus0.busy !== 1'b0 || bus0.dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_flags got busy=%b valid=%b want 0/0", bus0.busy, bus0.dout_valid); end
        bus0.din_valid = 1'b0; bus0.frame_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(0, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (bus0.sel !== 4'd1) begin n_fail++; $display("FAIL rm_first_slot got %0d want 1", bus0.sel); end
        for (int i = 1; i < 16; i++) send_bit(0, (i == 15), 1'b1, 1'b0);
        n_cmp++; if (bus0.dout !== 16'h8001) begin n_fail++; $display("FAIL rm_dout_after got %h want 8001", bus0.dout); end
        n_cmp++; if (bus0.dout_valid !== 1'b1) begin n_fail++; $display("FAIL rm_valid_after got %b want 1", bus0.dout_valid); end
    endtask

    task automatic test_msb_first;
        send_word(1, 16'h0001);
        n_cmp++; if (bus1.dout !== 16'h8000) begin n_fail++; $display("FAIL msb_slot0 got %h want 8000", bus1.dout); end
        send_word(1, 16'h8000);
        n_cmp++; if (bus1.dout !== 16'h0001) begin n_fail++; $display("FAIL msb_slot15 got %h want 0001", bus1.dout); end
        send_word(1, 16'hA5C3);
        n_cmp++; if (bus1.dout !== 16'hC3A5) begin n_fail++; $display("FAIL msb_pattern got %h want c3a5", bus1.dout); end
        n_cmp++; if (bus1.dout_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid got %b want 1", bus1.dout_valid); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_walking_one();
        test_gapped();
        test_backpressure();
        test_resync();
        test_reset_midframe();
        test_msb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 The block SHALL have parameter: LSB_FIRST, default 1, slot k maps to dout bit k when 1 and to dout bit 15-k when 0.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port: din  input  1  serial time-slot data bit.
REQ-005 The block SHALL have port: din_valid  input  1  din is valid this cycle.
REQ-006 The block SHALL have port: frame_start  input  1  forces the slot counter to slot 0 (frame resync).
REQ-007 The block SHALL have port: dout  output  16  last completed parallel word.
REQ-008 The block SHALL have port: dout_valid  output  1  dout holds an unconsumed word.
REQ-009 The block SHALL have port: dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 The block SHALL have port: sel  output  4  slot index the next valid din bit is written to.
REQ-011 The block SHALL have port: busy  output  1  partial frame in progress (sel != 0).
REQ-012 The block SHALL have port: overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 On a clock with din_valid=1 and frame_start=0, the block SHALL write din into shadow bit position sel and advance sel by 1, wrapping 15 -> 0.
REQ-014 On a clock with din_valid=1 and frame_start=1, the block SHALL write din into slot 0 and set sel to 1.
REQ-015 On a clock with frame_start=1 and din_valid=0, the block SHALL set sel to 0, discarding the partial frame, with no output change.
REQ-016 With din_valid=0 and frame_start=0, sel and the shadow register SHALL hold.
REQ-017 Shadow bits SHALL NOT be cleared between frames; every bit is overwritten by its slot.
REQ-018 A write to slot 15 completes a frame; the assembled 16-bit word including that bit SHALL appear on dout on the next clock edge (latency 1 cycle).
REQ-019 On completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 in the same cycle, dout SHALL load the new word and dout_valid SHALL be 1.
REQ-020 On completion with dout_valid=1 and dout_ready=0, dout SHALL retain the old word, the new word SHALL be dropped, and overrun SHALL set to 1.
REQ-021 With dout_valid=1, dout_ready=1 and no completion, dout_valid SHALL clear to 0 on the next edge; dout holds its value.
REQ-022 overrun SHALL remain 1 until reset.
REQ-023 busy SHALL be combinational (sel != 0).

Reset
REQ-024 On assertion of rst_n=0, the block SHALL asynchronously clear sel to 0, shadow to 16'h0000, dout to 16'h0000, dout_valid to 0, and overrun to 0.
REQ-025 A reset mid-frame SHALL discard the partial frame; the first valid bit after release goes to slot 0.

Verification
REQ-026 Walking one: 16 frames of 16 valid bits, frame k has din=1 only in slot k, dout_ready=1 -> dout = 16'h0001 << k, one dout_valid cycle per frame (k=5 gives 16'h0020).
REQ-027 Gapped input: frame 16'hA5C3 (LSB first) sent with din_valid deasserted every other cycle -> sel holds during gaps; dout=16'hA5C3 one cycle after the slot-15 bit.
REQ-028 Backpressure: dout_ready=0, frames 16'h1234 then 16'hFFFF -> dout stays 16'h1234, dout_valid=1, overrun=1. Then dout_ready=1 -> dout_valid=0 next edge, overrun still 1.
REQ-029 Resync: 7 valid bits, then frame_start with din_valid=0, then frame 16'h00FF -> dout=16'h00FF; the partial bits are not visible.
REQ-030 Reset mid-frame: rst_n low after 9 bits -> all outputs 0 immediately (asynchronous), sel=0; the next full frame 16'h8001 is captured correctly.
REQ-031 LSB_FIRST=0: serial stream 1,0,...,0 (slot 0 = 1) -> dout=16'h8000.
